// File: rtl/tile_map_bitmap.sv
// rtl/tile_map_bitmap.sv - writable two-level tile-map renderer with query port, reload sequencer and brick counter
module tile_map_bitmap #(
  parameter int         TILE_X_BITS          = 5,
  parameter int         TILE_Y_BITS          = 5,
  parameter int         MAP_COLS             = 17,
  parameter int         MAP_ROWS             = 11,
  parameter int         COL_BITS             = 5,
  parameter int         ROW_BITS             = 4,
  parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
  parameter logic [7:0] FILL_COLOR           = 8'hE0
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [10:0]         offsetX,
  input  logic [10:0]         offsetY,
  input  logic                InsideRectangle,
  output logic                drawingRequest,
  output logic [7:0]          RGBout,
  input  logic                wr_en,
  input  logic [COL_BITS-1:0] wr_col,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic [1:0]          wr_type,
  input  logic [COL_BITS-1:0] q_col,
  input  logic [ROW_BITS-1:0] q_row,
  output logic [1:0]          q_type,
  input  logic                reload_req,
  output logic                reload_busy,
  output logic [7:0]          brick_count
);

  localparam logic [1:0] T_EMPTY  = 2'd0;
  localparam logic [1:0] T_COLUMN = 2'd1;
  localparam logic [1:0] T_BRICK  = 2'd2;
  localparam logic [1:0] T_FILL   = 2'd3;

  typedef enum logic {S_RELOAD, S_IDLE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0] r_map [MAP_ROWS][MAP_COLS];

  logic [ROW_BITS-1:0]    r_rld_row;
  logic [COL_BITS-1:0]    r_rld_col;
  logic [1:0]             r_s1_type;
  logic [TILE_X_BITS-1:0] r_s1_x;
  logic [TILE_Y_BITS-1:0] r_s1_y;
  logic                   r_s1_inside;
  logic [7:0]             r_rgb;
  logic [1:0]             r_q_type;
  logic [7:0]             r_brick_count;

  logic [COL_BITS-1:0]    w_pix_col;
  logic [ROW_BITS-1:0]    w_pix_row;
  logic                   w_pix_over;
  logic [1:0]             w_pix_type;
  logic [7:0]             w_pix_rgb;
  logic                   w_rld_last;
  logic [1:0]             w_rld_type;
  logic                   w_reload_start;
  logic                   w_user_wr;
  logic [1:0]             w_wr_old;
  logic [1:0]             w_q_lookup;

  function automatic logic in_map(input logic [ROW_BITS-1:0] row, input logic [COL_BITS-1:0] col);
    return (int'(row) < MAP_ROWS) && (int'(col) < MAP_COLS);
  endfunction

  // Pixel address split; offsets beyond the addressable map are treated as empty rather than aliased
  always_comb begin
    w_pix_col  = offsetX[TILE_X_BITS+COL_BITS-1:TILE_X_BITS];
    w_pix_row  = offsetY[TILE_Y_BITS+ROW_BITS-1:TILE_Y_BITS];
    w_pix_over = ((offsetX >> (TILE_X_BITS+COL_BITS)) != '0) ||
                 ((offsetY >> (TILE_Y_BITS+ROW_BITS)) != '0);
    w_pix_type = T_EMPTY;
    if (!w_pix_over && in_map(w_pix_row, w_pix_col)) begin
      w_pix_type = r_map[w_pix_row][w_pix_col];
    end
  end

  // Reload sequencing, write qualification and old-value lookups (map reads see pre-edge contents)
  always_comb begin
    w_rld_last     = (int'(r_rld_row) == MAP_ROWS-1) && (int'(r_rld_col) == MAP_COLS-1);
    w_rld_type     = (!r_rld_row[0] && !r_rld_col[0]) ? T_COLUMN : T_EMPTY;
    w_reload_start = (r_state == S_IDLE) && reload_req;
    w_user_wr      = (r_state == S_IDLE) && wr_en && !reload_req && in_map(wr_row, wr_col);
    w_wr_old       = T_EMPTY;
    if (in_map(wr_row, wr_col)) begin
      w_wr_old = r_map[wr_row][wr_col];
    end
    w_q_lookup     = T_COLUMN;
    if (in_map(q_row, q_col)) begin
      w_q_lookup = r_map[q_row][q_col];
    end
  end

  // Next-state logic: reload runs to the last entry, a reload request restarts it from IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RELOAD: if (w_rld_last) w_state_next = S_IDLE;
      S_IDLE:   if (reload_req) w_state_next = S_RELOAD;
      default:  w_state_next = S_RELOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (resetN) r_state <= S_RELOAD;
    else        r_state <= w_state_next;
  end

  // Row-major reload index, restarted by reset or a new reload request
  always_ff @(posedge clk) begin
    if (resetN || w_reload_start) begin
      r_rld_row <= '0;
      r_rld_col <= '0;
    end else if (r_state == S_RELOAD) begin
      if (int'(r_rld_col) == MAP_COLS-1) begin
        r_rld_col <= '0;
        r_rld_row <= w_rld_last ? '0 : r_rld_row + 1'b1;
      end else begin
        r_rld_col <= r_rld_col + 1'b1;
      end
    end
  end

  // Map storage: reload writes the default layout, otherwise the runtime write port commits
  always_ff @(posedge clk) begin
    if (!resetN) begin
      if (r_state == S_RELOAD) begin
        r_map[r_rld_row][r_rld_col] <= w_rld_type;
      end else if (w_user_wr) begin
        r_map[wr_row][wr_col] <= wr_type;
      end
    end
  end

  // Live brick count tracks type-2 transitions at the write edge, saturating both ways
  always_ff @(posedge clk) begin
    if (resetN || w_reload_start) begin
      r_brick_count <= '0;
    end else if (w_user_wr) begin
      if (wr_type == T_BRICK && w_wr_old != T_BRICK && r_brick_count != 8'hFF) begin
        r_brick_count <= r_brick_count + 8'd1;
      end else if (wr_type != T_BRICK && w_wr_old == T_BRICK && r_brick_count != 8'h00) begin
        r_brick_count <= r_brick_count - 8'd1;
      end
    end
  end

  // Collision query; out-of-range cells read as solid column, zero while reloading
  always_ff @(posedge clk) begin
    if (resetN || w_state_next == S_RELOAD) r_q_type <= T_EMPTY;
    else                                    r_q_type <= w_q_lookup;
  end

  // Render stage 1: tile type and tile-local coordinates
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_s1_type   <= T_EMPTY;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_inside <= 1'b0;
    end else begin
      r_s1_type   <= w_pix_type;
      r_s1_x      <= offsetX[TILE_X_BITS-1:0];
      r_s1_y      <= offsetY[TILE_Y_BITS-1:0];
      r_s1_inside <= InsideRectangle;
    end
  end

  // Per-type pixel colour; column and brick ROMs are procedural patterns over tile-local x/y
  always_comb begin
    w_pix_rgb = TRANSPARENT_ENCODING;
    if (r_s1_inside) begin
      case (r_s1_type)
        T_COLUMN: w_pix_rgb = {r_s1_x[2:0], r_s1_y[2:0], 1'b1, ^{r_s1_x, r_s1_y}};
        T_BRICK:  w_pix_rgb = (r_s1_y[1:0] == 2'b11) ? TRANSPARENT_ENCODING
                                                     : {2'b10, r_s1_y[2:0], r_s1_x[2:0]};
        T_FILL:   w_pix_rgb = FILL_COLOR;
        default:  w_pix_rgb = TRANSPARENT_ENCODING;
      endcase
    end
  end

  // Render stage 2: colour register, forced transparent while reloading
  always_ff @(posedge clk) begin
    if (resetN || w_state_next == S_RELOAD) r_rgb <= TRANSPARENT_ENCODING;
    else                                    r_rgb <= w_pix_rgb;
  end

  assign RGBout         = r_rgb;
  assign drawingRequest = (r_rgb != TRANSPARENT_ENCODING);
  assign q_type         = r_q_type;
  assign reload_busy    = (r_state == S_RELOAD);
  assign brick_count    = r_brick_count;

endmodule

// File: tb/tb_tile_map_bitmap.sv
// tb/tb_tile_map_bitmap.sv - directed self-checking bench for tile_map_bitmap
module tb_tile_map_bitmap;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        wr_en;
  logic [4:0]  wr_col, q_col;
  logic [3:0]  wr_row, q_row;
  logic [1:0]  wr_type, q_type;
  logic        reload_req, reload_busy;
  logic [7:0]  brick_count;

  int errors = 0;
  int checks = 0;
  int n;
  int bad;

  always #5 clk = ~clk;

  tile_map_bitmap dut (
    .clk(clk), .resetN(resetN), .offsetX(offsetX), .offsetY(offsetY),
    .InsideRectangle(InsideRectangle), .drawingRequest(drawingRequest), .RGBout(RGBout),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_type(wr_type),
    .q_col(q_col), .q_row(q_row), .q_type(q_type),
    .reload_req(reload_req), .reload_busy(reload_busy), .brick_count(brick_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic query(input logic [3:0] row, input logic [4:0] col);
    q_row = row;
    q_col = col;
    tick();
  endtask

  task automatic write_tile(input logic [3:0] row, input logic [4:0] col, input logic [1:0] t);
    wr_en   = 1'b1;
    wr_row  = row;
    wr_col  = col;
    wr_type = t;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic count_reload(output int cycles);
    cycles = 0;
    while (reload_busy && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_default_map(input string tag);
    bad = 0;
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 32; c++) begin
        logic [1:0] e;
        e = (c >= 17) ? 2'd1 : ((r % 2 == 0 && c % 2 == 0) ? 2'd1 : 2'd0);
        query(4'(r), 5'(c));
        if (q_type !== e) bad++;
      end
    end
    check(tag, 16'(bad), 16'd0);
  endtask

  initial begin
    resetN = 1'b1; offsetX = '0; offsetY = '0; InsideRectangle = 1'b0;
    wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_type = '0;
    q_col = '0; q_row = '0; reload_req = 1'b0;
    repeat (3) tick();

    check("rst_busy", 16'(reload_busy), 16'd1);
    check("rst_rgb", 16'(RGBout), 16'h00FF);
    check("rst_dreq", 16'(drawingRequest), 16'd0);
    check("rst_qtype", 16'(q_type), 16'd0);
    check("rst_bricks", 16'(brick_count), 16'd0);

    resetN = 1'b0;
    count_reload(n);
    check("reload_cycles", 16'(n), 16'd187);

    query(4'd0, 5'd0);   check("q_0_0", 16'(q_type), 16'd1);
    query(4'd1, 5'd0);   check("q_1_0", 16'(q_type), 16'd0);
    query(4'd10, 5'd16); check("q_10_16", 16'(q_type), 16'd1);
    check("bricks_after_reload", 16'(brick_count), 16'd0);

    InsideRectangle = 1'b1;
    offsetX = 11'd0; offsetY = 11'd0;
    tick();
    offsetX = 11'd40;
    tick();
    check("col_rom_0_0", 16'(RGBout), 16'h0002);
    check("col_dreq", 16'(drawingRequest), 16'd1);
    tick();
    check("empty_rgb", 16'(RGBout), 16'h00FF);
    check("empty_dreq", 16'(drawingRequest), 16'd0);

    write_tile(4'd1, 5'd1, 2'd3);
    offsetX = 11'd32; offsetY = 11'd32;
    tick();
    check("fill_latency_1", 16'(RGBout), 16'h00FF);
    tick();
    check("fill_latency_2", 16'(RGBout), 16'h00E0);
    bad = 0;
    for (int y = 32; y < 64; y++) begin
      for (int x = 32; x < 64; x++) begin
        offsetX = 11'(x); offsetY = 11'(y);
        tick();
        tick();
        if (RGBout !== 8'hE0 || drawingRequest !== 1'b1) bad++;
      end
    end
    check("fill_sweep", 16'(bad), 16'd0);

    write_tile(4'd1, 5'd1, 2'd2); check("bricks_1", 16'(brick_count), 16'd1);
    write_tile(4'd1, 5'd3, 2'd2); check("bricks_2", 16'(brick_count), 16'd2);
    write_tile(4'd1, 5'd1, 2'd0); check("bricks_3", 16'(brick_count), 16'd1);
    write_tile(4'd1, 5'd3, 2'd2); check("bricks_rewrite", 16'(brick_count), 16'd1);

    offsetX = 11'd96; offsetY = 11'd32;
    tick(); tick();
    check("brick_rom_0_0", 16'(RGBout), 16'h0080);
    offsetY = 11'd35;
    tick(); tick();
    check("brick_mortar_rgb", 16'(RGBout), 16'h00FF);
    check("brick_mortar_dreq", 16'(drawingRequest), 16'd0);

    wr_en = 1'b1; wr_row = 4'd1; wr_col = 5'd1; wr_type = 2'd2;
    q_row = 4'd1; q_col = 5'd1;
    tick();
    wr_en = 1'b0;
    check("rbw_old", 16'(q_type), 16'd0);
    check("rbw_bricks", 16'(brick_count), 16'd2);
    tick();
    check("rbw_new", 16'(q_type), 16'd2);
    query(4'd12, 5'd0); check("q_row_oob", 16'(q_type), 16'd1);
    query(4'd0, 5'd17); check("q_col_oob", 16'(q_type), 16'd1);
    write_tile(4'd11, 5'd0, 2'd2); check("oob_write_dropped", 16'(brick_count), 16'd2);

    offsetX = 11'd0; offsetY = 11'd0;
    reload_req = 1'b1;
    wr_en = 1'b1; wr_row = 4'd0; wr_col = 5'd1; wr_type = 2'd2;
    tick();
    reload_req = 1'b0;
    wr_en = 1'b0;
    check("reload_busy_set", 16'(reload_busy), 16'd1);
    check("reload_bricks_cleared", 16'(brick_count), 16'd0);
    n = 0;
    while (reload_busy && n < 400) begin
      wr_en = n[0];
      reload_req = (n == 20);
      tick();
      n++;
      if (n == 10) begin
        check("reload_rgb_forced", 16'(RGBout), 16'h00FF);
        check("reload_qtype_zero", 16'(q_type), 16'd0);
      end
    end
    wr_en = 1'b0;
    reload_req = 1'b0;
    check("reload2_cycles", 16'(n), 16'd187);
    check("reload2_bricks", 16'(brick_count), 16'd0);
    check_default_map("reload2_map_default");

    write_tile(4'd1, 5'd1, 2'd2);
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    repeat (49) tick();
    check("busy_at_50", 16'(reload_busy), 16'd1);
    resetN = 1'b1;
    tick();
    resetN = 1'b0;
    count_reload(n);
    check("reset_restart_cycles", 16'(n), 16'd187);
    check("reset_restart_bricks", 16'(brick_count), 16'd0);
    check_default_map("reset_restart_map_default");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_map_bitmap.md
Name: tile_map_bitmap

Overview:
- Parametrised, writable two-level tile-map renderer for the playfield.
- Stores a MAP_ROWS x MAP_COLS map of tile-type codes. Maps each in-rectangle pixel to a tile type, then to a per-type 2^TILE_X_BITS x 2^TILE_Y_BITS bitmap or a flat fill.
- Adds three things over the fixed column mask:
  - a runtime write port, so game logic can place and destroy bricks;
  - a collision query port;
  - a sequenced reload of the default layout.
- A live brick counter supports level-clear detection.

Parameters:
- TILE_X_BITS, 5, log2 of tile width in pixels.
- TILE_Y_BITS, 5, log2 of tile height in pixels.
- MAP_COLS, 17, tiles per row.
- MAP_ROWS, 11, tile rows.
- COL_BITS, 5, width of column index; must satisfy 2^COL_BITS >= MAP_COLS.
- ROW_BITS, 4, width of row index; must satisfy 2^ROW_BITS >= MAP_ROWS.
- TRANSPARENT_ENCODING, 8'hFF, RGB code meaning "do not draw".
- FILL_COLOR, 8'hE0, flat colour drawn for type 3.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-high reset.
- offsetX  in  11  pixel X offset from top-left of playfield.
- offsetY  in  11  pixel Y offset from top-left of playfield.
- InsideRectangle  in  1  pixel lies within the playfield bracket.
- drawingRequest  out  1  pixel should be displayed.
- RGBout  out  8  pixel colour.
- wr_en  in  1  write tile-map entry.
- wr_col  in  COL_BITS  write column.
- wr_row  in  ROW_BITS  write row.
- wr_type  in  2  tile type to write.
- q_col  in  COL_BITS  query column.
- q_row  in  ROW_BITS  query row.
- q_type  out  2  type at (q_row, q_col), registered.
- reload_req  in  1  request reload of the default layout (one-cycle pulse).
- reload_busy  out  1  reload in progress.
- brick_count  out  8  number of type-2 tiles currently in the map.

Behaviour:
- Tile types:
  - 0: empty, always transparent.
  - 1: column, indestructible; per-pixel colour from column ROM.
  - 2: brick; per-pixel colour from brick ROM.
  - 3: flat FILL_COLOR (explosion flash).
  - ROM pixels equal to TRANSPARENT_ENCODING stay transparent.
- Address split:
  - col = offsetX[TILE_X_BITS+COL_BITS-1 : TILE_X_BITS]; row likewise from offsetY.
  - Tile-local x/y = low TILE_X_BITS / TILE_Y_BITS bits of the offsets.
  - col >= MAP_COLS or row >= MAP_ROWS is treated as type 0.
- Render pipeline, 2-cycle latency:
  - Stage 1 registers tile type, local x/y and InsideRectangle.
  - Stage 2 registers RGBout.
  - InsideRectangle=0 yields TRANSPARENT_ENCODING.
  - drawingRequest = (RGBout != TRANSPARENT_ENCODING), combinational from the register.
- FSM states are RELOAD and IDLE.
  - Reset forces RELOAD, index 0, RGBout=TRANSPARENT_ENCODING, q_type=0, brick_count=0, reload_busy=1. Map contents during reset are don't-care.
  - RELOAD writes one entry per cycle in row-major order, starting at (0,0).
  - Default layout: type 1 where row and col are both even, else type 0.
  - After entry (MAP_ROWS-1, MAP_COLS-1) the FSM goes to IDLE; reload_busy drops the next cycle. Total MAP_ROWS*MAP_COLS cycles busy (187 at defaults).
  - In RELOAD: render outputs forced transparent; wr_en ignored; reload_req ignored; q_type=0.
  - IDLE to RELOAD on reload_req=1; brick_count is cleared in the same transition.
- Write port, IDLE only:
  - wr_en commits at the clock edge.
  - Out-of-range coordinates are silently dropped.
  - reload_req and wr_en in the same cycle: reload wins and the write is dropped.
- Read-before-write:
  - A stage-1 render lookup or a query of the cell being written in the same cycle returns the old type.
  - The new type is visible from the next cycle.
- Query: q_type is registered with 1-cycle latency. Out-of-range coordinates return type 1, so movement beyond the map is blocked.
- brick_count, updated in the same edge as the write:
  - +1 when writing type 2 over a non-2 tile.
  - -1 when writing a non-2 type over type 2.
  - Unchanged otherwise.
  - Saturates at 255 and does not go below 0.
- Reset mid-reload restarts the reload from index 0.

Test Plan:
- Deassert reset, hold 187 cycles -> reload_busy=1 for exactly 187 cycles. Then q at (0,0)=1, (1,0)=0, (10,16)=1, brick_count=0.
- IDLE, InsideRectangle=1, offset (0,0) then (40,0) -> two cycles later RGBout = column ROM[0][0], then 8'hFF with drawingRequest=0.
- Write type 3 at (row 1, col 1); sweep offset (32..63, 32..63) -> every pixel RGBout=8'hE0, drawingRequest=1, 2-cycle latency.
- Write type 2 at (1,1) and (1,3), then type 0 at (1,1) -> brick_count goes 1, 2, 1. Rewriting type 2 over (1,3) leaves it at 1.
- Same-cycle wr_en (1,1)=2 and query (1,1) -> q_type returns the old value. Query the next cycle returns 2. Query (row 12, col 0) -> 1.
- reload_req with simultaneous wr_en, and wr_en pulses during busy -> write dropped, map equals default after 187 cycles, brick_count=0. Reset at cycle 50 restarts the 187-cycle reload.
